dot_product_sequencer: RTL and testbench

- Issue stage directly upstream of the unsigned_muladd_1_stage_26_17_48_bit DSP48E2 slice.
- Accepts a valid/ready stream of (a, b) operand beats grouped into vectors by a last flag. Drives the slice's a/b/c inputs every cycle, feeding the slice's registered out back as c to build a running sum.
- Captures each finished dot product (bias + sum of a*b) into a one-entry result buffer with its own valid/ready handshake.

---
 rtl/dot_product_sequencer_if.sv | 31 +++
 rtl/dot_product_sequencer.sv | 56 +++++
 tb/tb_dot_product_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dot_product_sequencer_if.sv
// dot_product_sequencer_if: operand stream, DSP slice drive and result handshake
interface dot_product_sequencer_if #(
  parameter int A_W   = 26,
  parameter int B_W   = 17,
  parameter int P_W   = 48,
  parameter int LEN_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [P_W-1:0]   in_bias;
  logic             in_last;
  logic [A_W-1:0]   mac_a;
  logic [B_W-1:0]   mac_b;
  logic [P_W-1:0]   mac_c;
  logic [P_W-1:0]   mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   res_data;
  logic [LEN_W-1:0] res_len;
  logic             res_err;
  modport master (
    output in_valid, in_a, in_b, in_bias, in_last, mac_out, res_ready,
    input  in_ready, mac_a, mac_b, mac_c, res_valid, res_data, res_len, res_err
  );
  modport slave (
    input  in_valid, in_a, in_b, in_bias, in_last, mac_out, res_ready,
    output in_ready, mac_a, mac_b, mac_c, res_valid, res_data, res_len, res_err
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: issues operand beats to a 1-cycle muladd slice and buffers each finished dot product
module dot_product_sequencer #(
  parameter int A_W     = 26,
  parameter int B_W     = 17,
  parameter int P_W     = 48,
  parameter int MAX_LEN = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  dot_product_sequencer_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, len_q;
  logic             err_q;
  logic             fire, tlast;
  assign bus.in_ready = (state != DONE) && (!bus.res_valid || bus.res_ready);
  assign fire         = bus.in_valid && bus.in_ready;
  assign tlast        = fire && (bus.in_last || cnt == LEN_W'(MAX_LEN - 1));
  assign bus.mac_a    = fire ? bus.in_a : '0;
  assign bus.mac_b    = fire ? bus.in_b : '0;
  // outside IDLE the slice register holds the running sum and is fed straight back
  assign bus.mac_c    = state == IDLE ? (fire ? bus.in_bias : '0) : bus.mac_out;
  always_comb begin
    state_n = state;
    state_n = tlast ? DONE : state == DONE ? IDLE : (state == IDLE && fire) ? ACC : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      err_q         <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_len   <= '0;
      bus.res_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= tlast ? '0 : fire ? cnt + 1'b1 : cnt;
      if (tlast) begin
        len_q <= cnt + 1'b1;
        err_q <= !bus.in_last;
      end
      if (state == DONE) begin
        bus.res_valid <= 1'b1;
        bus.res_data  <= bus.mac_out;
        bus.res_len   <= len_q;
        bus.res_err   <= err_q;
      end else if (bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: directed and random vectors against a dot-product scoreboard, with a slice model
module tb_dot_product_sequencer;
  localparam int A_W = 26, B_W = 17, P_W = 48, MAX_LEN = 4;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef struct {logic [P_W-1:0] d; int n; bit e;} res_t;
  logic clk = 0, rst_n = 0;
  int   pass_cnt = 0, tot_cnt = 0;
  bit   rand_rdy = 0;
  res_t exp_q[$];
  logic [P_W-1:0] m_sum;
  int   m_n = 0;
  dot_product_sequencer_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W)) bus ();
  dot_product_sequencer #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  // behavioural DSP slice: out = a*b + c, one register, no reset
  always @(posedge clk) bus.mac_out <= P_W'(bus.mac_a) * P_W'(bus.mac_b) + bus.mac_c;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic beat(logic [A_W-1:0] a, logic [B_W-1:0] b, logic [P_W-1:0] bias, bit last);
    bit ok = 0;
    bus.in_valid = 1; bus.in_a = a; bus.in_b = b; bus.in_bias = bias; bus.in_last = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        if (m_n == 0) m_sum = bias;
        m_sum = m_sum + P_W'(a) * P_W'(b);
        m_n++;
        if (last || m_n == MAX_LEN) begin
          exp_q.push_back('{m_sum, m_n, !last});
          m_n = 0;
        end
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    bus.in_valid = 0;
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) bus.res_ready = ($urandom_range(0, 3) != 0);
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_len_err", {bus.res_len, bus.res_err}, 0);
    end else if (bus.res_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", bus.res_valid, 0);
      else begin
        chk("sb_res_data", bus.res_data, exp_q[0].d);
        chk("sb_res_len", bus.res_len, 64'(exp_q[0].n));
        chk("sb_res_err", bus.res_err, 64'(exp_q[0].e));
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_bias = 0; bus.in_last = 0;
    bus.res_ready = 1;
    idle(3);
    chk("rst_in_mac", {bus.mac_a, bus.mac_b, bus.mac_c}, 0);
    rst_n = 1;
    idle(2);
    beat(3, 7, 100, 0);
    beat(5, 11, 100, 1);
    chk("t1_in_ready_done", bus.in_ready, 0);
    chk("t1_valid_not_yet", bus.res_valid, 0);
    idle(1);
    chk("t1_res_valid", bus.res_valid, 1);
    chk("t1_res_data", bus.res_data, 176);
    chk("t1_res_len", bus.res_len, 2);
    chk("t1_res_err", bus.res_err, 0);
    chk("t1_in_ready_back", bus.in_ready, 1);
    beat(3, 7, 100, 0);
    repeat (3) begin @(negedge clk); chk("t2_bubble_mac_c", bus.mac_c, 121); @(posedge clk); #1; end
    beat(5, 11, 100, 1);
    idle(1);
    chk("t2_res_data", bus.res_data, 176);
    beat('1, '1, '1, 1);
    idle(1);
    chk("t3_wrap_data", bus.res_data, 48'd8796025782272);
    chk("t3_wrap_len", bus.res_len, 1);
    repeat (4) beat(1, 1, 0, 0);
    idle(1);
    chk("t4_max_data", bus.res_data, 4);
    chk("t4_max_len", bus.res_len, 4);
    chk("t4_max_err", bus.res_err, 1);
    beat(1, 1, 0, 1);
    idle(1);
    chk("t4_next_data", bus.res_data, 1);
    chk("t4_next_len_err", {bus.res_len, bus.res_err}, {3'd1, 1'b0});
    idle(1);
    bus.res_ready = 0;
    beat(3, 7, 100, 0);
    beat(5, 11, 100, 1);
    idle(1);
    bus.in_valid = 1; bus.in_a = 2; bus.in_b = 2; bus.in_bias = 0; bus.in_last = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_bp_in_ready", bus.in_ready, 0);
      chk("t5_bp_hold", bus.res_data, 176);
      @(posedge clk); #1;
    end
    bus.res_ready = 1;
    beat(2, 2, 0, 1);
    bus.res_ready = 0;
    chk("t5_consumed", bus.res_valid, 0);
    idle(1);
    chk("t5_new_data", bus.res_data, 4);
    bus.res_ready = 1;
    idle(1);
    beat(9, 9, 0, 0);
    rst_n = 0;
    m_n = 0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_mac", {bus.mac_a, bus.mac_b, bus.mac_c}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    beat(1, 1, 0, 1);
    idle(1);
    chk("t6_after_rst_data", bus.res_data, 1);
    chk("t6_after_rst_len", bus.res_len, 1);
    rand_rdy = 1;
    for (int v = 0; v < 150; v++) begin
      int len = $urandom_range(1, 6);
      logic [P_W-1:0] bias = {$urandom, $urandom};
      for (int i = 0; i < len; i++) begin
        logic [A_W-1:0] a = $urandom;
        logic [B_W-1:0] b = $urandom;
        if ($urandom_range(0, 7) == 0) begin a = '1; b = '1; end
        idle($urandom_range(0, 2));
        beat(a, b, bias, i == len - 1);
      end
    end
    rand_rdy = 0;
    idle(1);
    bus.res_ready = 1;
    idle(10);
    chk("drain_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
